sram_pipe: RTL

Parametrised single-port SRAM with a valid/ready request interface, bit-masked writes, a configurable fixed read-latency pipeline and a self-clearing initialisation sweep after reset. It replaces the bare `sram` node store in the BDD accelerator. Node-table clients can issue one request per cycle once initialisation completes and can partially update packed node fields, such as the 10-bit index or one 8-bit child field, without a read-modify-write.

---
 rtl/sram_pipe.sv | 134 +++++++++++++
 1 files changed

// File: rtl/sram_pipe.sv
// sram_pipe: single-port node-table SRAM with a valid/ready request port,
// bit-masked writes, a fixed READ_LAT response pipeline and an init sweep
// that writes INIT_VALUE to every word after reset.
module sram_pipe #(
    parameter int unsigned           ADDR_WIDTH = 5,
    parameter int unsigned           DATA_WIDTH = 34,
    parameter int unsigned           DEPTH      = 32,
    parameter int unsigned           READ_LAT   = 2,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_write,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [DATA_WIDTH-1:0] i_wmask,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic                  o_rsp_err,
    output logic                  o_busy
);

    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
        $error("sram_pipe: READ_LAT must be in 1..4");
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("sram_pipe: DEPTH must be in 1..2**ADDR_WIDTH");
    end

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    init_we;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    vld_q [READ_LAT];
    logic                    err_q [READ_LAT];
    logic [DATA_WIDTH-1:0]   dat_q [READ_LAT];

    logic                    run;
    logic                    addr_ok;
    logic                    wr_acc;
    logic                    rd_acc;
    logic [DATA_WIDTH-1:0]   rd_data;

    assign run     = (state_q == ST_RUN);
    assign addr_ok = ({1'b0, i_addr} < DEPTH_W);
    assign wr_acc  = run & i_req_valid & i_write & addr_ok;
    assign rd_acc  = run & i_req_valid & ~i_write;
    assign rd_data = addr_ok ? mem_q[i_addr] : '0;

    // Next state: sweep the counter through every word, then serve requests.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_we = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_we = 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // State register; reset always restarts the sweep from word 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage: init sweep writes whole words, requests merge under the mask.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (init_we) begin
                mem_q[cnt_q] <= INIT_VALUE;
            end else if (wr_acc) begin
                mem_q[i_addr] <= (mem_q[i_addr] & ~i_wmask) | (i_data & i_wmask);
            end
        end
    end

    // Read pipeline: data/err only advance with a valid, so the last stage
    // keeps the previous response visible between pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < READ_LAT; i++) begin
                vld_q[i] <= 1'b0;
                err_q[i] <= 1'b0;
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_acc;
            if (rd_acc) begin
                dat_q[0] <= rd_data;
                err_q[0] <= ~addr_ok;
            end
            for (int unsigned i = 1; i < READ_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                    err_q[i] <= err_q[i-1];
                end
            end
        end
    end

    assign o_req_ready = run;
    assign o_busy      = ~run;
    assign o_rsp_valid = vld_q[READ_LAT-1];
    assign o_rsp_data  = dat_q[READ_LAT-1];
    assign o_rsp_err   = err_q[READ_LAT-1];

endmodule
